// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: default table size and 2-bit counter encodings.
// Holds no logic, so it adds no latency and exerts no backpressure.
package bp_pkg;

    localparam int BP_IDX_W = 4;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    // New entries start weakly taken; reset leaves counters weakly not-taken.
    localparam logic [1:0] CNT_ALLOC = CNT_WT;
    localparam logic [1:0] CNT_RST   = CNT_WNT;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
// Purely combinational; no backpressure.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_nxt
);

    always_comb begin
        cnt_nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) cnt_nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup on pcF registered into D, trained by resolved E-stage branches.
// Lookup latency 1 cycle; stallD holds and flushD clears the D register (flush wins); updates are never refused.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pcF,
    input  logic              stallD,
    input  logic              flushD,
    output logic              btb_hitD,
    output logic              btb_takeD,
    output logic [31:0]       btb_targetD,
    input  logic              upd_en,
    input  logic [31:0]       upd_pc,
    input  logic [31:0]       upd_target,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic               hit_q, hit_d;
    logic               take_q, take_d;
    logic [31:0]        target_q, target_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0]   f_tag, u_tag;
    logic               f_hit, f_take;
    logic [31:0]        f_tgt;
    logic               u_hit, u_alloc, u_train, u_tgt_wr;
    logic [1:0]         u_ctr_nxt;
    logic               unused_pc_lsbs;

    assign unused_pc_lsbs = ^{pcF[1:0], upd_pc[1:0]};

    assign f_idx  = pcF[IDX_W+1:2];
    assign f_tag  = pcF[31:IDX_W+2];
    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_take = f_hit && ctr_q[f_idx][1];
    assign f_tgt  = f_hit ? tgt_q[f_idx] : 32'd0;

    assign u_idx    = upd_pc[IDX_W+1:2];
    assign u_tag    = upd_pc[31:IDX_W+2];
    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_train  = upd_en && u_hit;
    assign u_alloc  = upd_en && !u_hit && upd_taken;
    // A taken outcome writes the target whether it trains an entry or allocates one.
    assign u_tgt_wr = upd_en && upd_taken;

    sat_counter2 u_ctr (
        .cnt     (ctr_q[u_idx]),
        .taken   (upd_taken),
        .cnt_nxt (u_ctr_nxt)
    );

    always_comb begin
        hit_d         = hit_q;
        take_d        = take_q;
        target_d      = target_q;
        hit_cnt_d     = hit_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (flushD) begin
            hit_d    = 1'b0;
            take_d   = 1'b0;
            target_d = 32'd0;
        end else if (!stallD) begin
            hit_d    = f_hit;
            take_d   = f_take;
            target_d = f_tgt;
            if (f_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if (upd_en && upd_mispredict && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q         <= 1'b0;
            take_q        <= 1'b0;
            target_q      <= 32'd0;
            hit_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            hit_q         <= hit_d;
            take_q        <= take_d;
            target_q      <= target_d;
            hit_cnt_q     <= hit_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CNT_RST;
        end else if (u_alloc) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= CNT_ALLOC;
        end else if (u_train) begin
            ctr_q[u_idx]   <= u_ctr_nxt;
        end
    end

    // Tag/target carry no reset; the rst gate keeps an update coincident with reset from landing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (u_alloc)  tag_q[u_idx] <= u_tag;
            if (u_tgt_wr) tgt_q[u_idx] <= upd_target;
        end
    end

    assign btb_hitD    = hit_q;
    assign btb_takeD   = take_q;
    assign btb_targetD = target_q;
    assign hit_cnt     = hit_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: vector table plus stall/flush and mid-run reset sequences.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        stallD, flushD;
    logic        btb_hitD, btb_takeD;
    logic [31:0] btb_targetD;
    logic        upd_en;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken, upd_mispredict;
    logic [31:0] hit_cnt, mispred_cnt;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] PC_B = 32'h0040_1010;
    localparam logic [31:0] PC_C = 32'h0040_0020;
    localparam logic [31:0] PC_D = 32'h0040_0080;
    localparam logic [31:0] T1   = 32'h0040_0100;
    localparam logic [31:0] T2   = 32'h0040_2000;
    localparam logic [31:0] T3   = 32'h0040_3000;

    branch_target_buffer #(.IDX_W(4), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pcF            (pcF),
        .stallD         (stallD),
        .flushD         (flushD),
        .btb_hitD       (btb_hitD),
        .btb_takeD      (btb_takeD),
        .btb_targetD    (btb_targetD),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .hit_cnt        (hit_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic        ue;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        umis;
        logic        eh;
        logic        et;
        logic [31:0] etg;
        int          ehc;
        int          emc;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(logic [31:0] pcf, logic ue, logic [31:0] upc, logic [31:0] utgt,
                                logic utk, logic umis, logic eh, logic et, logic [31:0] etg,
                                int ehc, int emc);
        vec_t v;
        v.pcf = pcf; v.ue = ue; v.upc = upc; v.utgt = utgt; v.utk = utk; v.umis = umis;
        v.eh = eh; v.et = et; v.etg = etg; v.ehc = ehc; v.emc = emc;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_out(string tag, logic eh, logic et, logic [31:0] etg, int ehc, int emc);
        check({tag, " hitD"},    {31'd0, btb_hitD},  {31'd0, eh});
        check({tag, " takeD"},   {31'd0, btb_takeD}, {31'd0, et});
        check({tag, " targetD"}, btb_targetD, etg);
        check({tag, " hit_cnt"}, hit_cnt, ehc);
        check({tag, " mispred"}, mispred_cnt, emc);
    endtask

    task automatic drive(logic [31:0] pcf, logic st, logic fl, logic ue, logic [31:0] up,
                         logic [31:0] ut, logic tk, logic mp);
        pcF = pcf; stallD = st; flushD = fl;
        upd_en = ue; upd_pc = up; upd_target = ut; upd_taken = tk; upd_mispredict = mp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'd0, 0, 0, 0, 32'd0, 32'd0, 0, 0);

        vecs[0]  = mk(PC_A, 0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 0, 0);
        vecs[1]  = mk(PC_A, 1, PC_A,  T1,    1, 0, 0, 0, 32'd0, 0, 0);
        vecs[2]  = mk(PC_A, 0, 32'd0, 32'd0, 0, 0, 1, 1, T1,    1, 0);
        vecs[3]  = mk(PC_A, 1, PC_A,  T1,    0, 0, 1, 1, T1,    2, 0);
        vecs[4]  = mk(PC_A, 1, PC_A,  T1,    0, 0, 1, 0, T1,    3, 0);
        vecs[5]  = mk(PC_A, 1, PC_A,  T1,    0, 0, 1, 0, T1,    4, 0);
        vecs[6]  = mk(PC_A, 0, 32'd0, 32'd0, 0, 0, 1, 0, T1,    5, 0);
        vecs[7]  = mk(PC_A, 1, PC_B,  T2,    1, 0, 1, 0, T1,    6, 0);
        vecs[8]  = mk(PC_A, 0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 6, 0);
        vecs[9]  = mk(PC_B, 0, 32'd0, 32'd0, 0, 0, 1, 1, T2,    7, 0);
        vecs[10] = mk(PC_B, 1, PC_B,  T2,    1, 0, 1, 1, T2,    8, 0);
        vecs[11] = mk(PC_B, 1, PC_B,  T2,    1, 0, 1, 1, T2,    9, 0);
        vecs[12] = mk(PC_B, 1, PC_B,  32'hDEAD_0000, 0, 0, 1, 1, T2, 10, 0);
        vecs[13] = mk(PC_B, 0, 32'd0, 32'd0, 0, 0, 1, 1, T2,    11, 0);
        vecs[14] = mk(PC_C, 1, PC_C,  32'h0040_9000, 0, 0, 0, 0, 32'd0, 11, 0);
        vecs[15] = mk(PC_C, 0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 11, 0);
        vecs[16] = mk(PC_B, 1, PC_B,  T3,    1, 0, 1, 1, T2,    12, 0);
        vecs[17] = mk(PC_B, 0, 32'd0, 32'd0, 0, 0, 1, 1, T3,    13, 0);
        vecs[18] = mk(PC_B | 32'd3, 0, 32'd0, 32'd0, 0, 0, 1, 1, T3, 14, 0);
        for (int i = 0; i < 5; i++)
            vecs[19+i] = mk(PC_C, 1, PC_D, 32'd0, 0, 1, 0, 0, 32'd0, 14, i + 1);
        vecs[24] = mk(PC_C, 0, PC_D, 32'd0, 0, 1, 0, 0, 32'd0, 14, 5);

        step();
        step();
        check_out("reset", 0, 0, 32'd0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].pcf, 0, 0, vecs[i].ue, vecs[i].upc, vecs[i].utgt, vecs[i].utk, vecs[i].umis);
            step();
            check_out($sformatf("v%0d", i), vecs[i].eh, vecs[i].et, vecs[i].etg, vecs[i].ehc, vecs[i].emc);
        end

        // Stall freezes D outputs and hit_cnt; flush clears outputs even under stall.
        drive(PC_B, 0, 0, 0, 32'd0, 32'd0, 0, 0);
        step();
        check_out("pre_stall", 1, 1, T3, 15, 5);
        drive(PC_C, 1, 0, 0, 32'd0, 32'd0, 0, 0); step(); check_out("stall0", 1, 1, T3, 15, 5);
        drive(PC_A, 1, 0, 0, 32'd0, 32'd0, 0, 0); step(); check_out("stall1", 1, 1, T3, 15, 5);
        drive(PC_B, 1, 0, 0, 32'd0, 32'd0, 0, 0); step(); check_out("stall2", 1, 1, T3, 15, 5);
        drive(PC_B, 1, 1, 0, 32'd0, 32'd0, 0, 0); step(); check_out("flush_stall", 0, 0, 32'd0, 15, 5);
        drive(PC_B, 0, 1, 0, 32'd0, 32'd0, 0, 0); step(); check_out("flush_only", 0, 0, 32'd0, 15, 5);
        drive(PC_B, 0, 0, 0, 32'd0, 32'd0, 0, 0); step(); check_out("post_flush", 1, 1, T3, 16, 5);

        // Asynchronous reset mid-cycle, with an update held across a reset edge.
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 32'd0, 0, 0);
        drive(PC_B, 0, 0, 1, PC_C, T1, 1, 1);
        step();
        check_out("rst_upd", 0, 0, 32'd0, 0, 0);
        rst = 1'b0;
        drive(PC_C, 0, 0, 0, 32'd0, 32'd0, 0, 0);
        step();
        check_out("after_rst_c", 0, 0, 32'd0, 0, 0);
        drive(PC_B, 0, 0, 0, 32'd0, 32'd0, 0, 0);
        step();
        check_out("after_rst_b", 0, 0, 32'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
